// File: rtl/acc_sequencer.sv
// acc_sequencer: CPU-programmed load/compute/store bus master for the matrix-multiply accelerator
// Ports: s_mem_* register slave (CTRL/STATUS/SRC_A/SRC_B/DST at CFG_BASE), m_mem_* memory master,
//        busy = sequence running, irq = done | error (level).
module acc_sequencer #(
  parameter logic [31:0] CFG_BASE  = 32'h0160_0000,
  parameter logic [31:0] ACC_WRITE = 32'h0110_0000,
  parameter logic [31:0] ACC_READ  = 32'h0130_0000,
  parameter int          A_WORDS   = 1,
  parameter int          B_WORDS   = 4,
  parameter int          RES_WORDS = 2,
  parameter int          TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_mem_valid,
  input  logic [31:0] s_mem_addr,
  input  logic [31:0] s_mem_wdata,
  input  logic [3:0]  s_mem_wstrb,
  output logic        s_mem_ready,
  output logic [31:0] s_mem_rdata,
  output logic        m_mem_valid,
  output logic [31:0] m_mem_addr,
  output logic [31:0] m_mem_wdata,
  output logic [3:0]  m_mem_wstrb,
  input  logic        m_mem_ready,
  input  logic [31:0] m_mem_rdata,
  output logic        busy,
  output logic        irq
);
  localparam logic [2:0] IDLE = 3'd0, LOAD_RD = 3'd1, LOAD_WR = 3'd2, RES_RD = 3'd3, RES_WR = 3'd4, ERR = 3'd5;
  localparam logic [15:0] A_N = 16'(A_WORDS);
  localparam logic [15:0] LD_LAST = 16'(A_WORDS + B_WORDS - 1);
  localparam logic [15:0] RES_LAST = 16'(RES_WORDS - 1);
  localparam logic [15:0] WD_MAX = 16'(TIMEOUT - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] idx_q, idx_d, wd_q, wd_d;
  logic [31:0] data_q, data_d;
  logic        m_valid_q, m_valid_d;
  logic [31:0] m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
  logic [3:0]  m_wstrb_q, m_wstrb_d;
  logic [31:0] src_a_q, src_a_d, src_b_q, src_b_d, dst_q, dst_d;
  logic        done_q, done_d, error_q, error_d;
  logic        s_ready_q, s_ready_d;
  logic [31:0] s_rdata_q, s_rdata_d;

  logic [31:0] off, ofs, ofs_b, req_addr;
  logic        hit, wr_s, cfg_wr, st_wr, start, is_wr, m_ack, issue, tmo, last_res;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return ((old & ~m) | (d & m)) & 32'hFFFF_FFFC;
  endfunction

  // Slave decode: one ack per access, so a held valid is not re-acked while ready is high.
  assign off    = s_mem_addr - CFG_BASE;
  assign hit    = s_mem_valid && off <= 32'd16 && off[1:0] == 2'b00 && !s_ready_q;
  assign wr_s   = hit && |s_mem_wstrb;
  assign busy   = state_q != IDLE && state_q != ERR;
  assign cfg_wr = wr_s && !busy;
  assign st_wr  = wr_s && off == 32'd4 && s_mem_wstrb[0];
  assign start  = wr_s && off == 32'd0 && s_mem_wstrb[0] && s_mem_wdata[0] && !busy;

  assign src_a_d = cfg_wr && off == 32'd8  ? merge(src_a_q, s_mem_wdata, s_mem_wstrb) : src_a_q;
  assign src_b_d = cfg_wr && off == 32'd12 ? merge(src_b_q, s_mem_wdata, s_mem_wstrb) : src_b_q;
  assign dst_d   = cfg_wr && off == 32'd16 ? merge(dst_q, s_mem_wdata, s_mem_wstrb) : dst_q;

  assign s_ready_d = hit;
  assign s_rdata_d = !hit            ? 32'h0 :
                     off == 32'd4    ? {29'd0, error_q, done_q, busy} :
                     off == 32'd8    ? src_a_q :
                     off == 32'd12   ? src_b_q :
                     off == 32'd16   ? dst_q : 32'h0;

  // Master side: a new request needs a fully idle cycle (valid=0, ready=0) so a
  // lingering registered ready from the previous slave cannot ack it.
  assign is_wr    = state_q == LOAD_WR || state_q == RES_WR;
  assign m_ack    = m_valid_q && m_mem_ready;
  assign issue    = busy && !m_valid_q && !m_mem_ready;
  assign tmo      = m_valid_q && !m_mem_ready && wd_q == WD_MAX;
  assign last_res = state_q == RES_WR && idx_q == RES_LAST;
  assign ofs      = {14'd0, idx_q, 2'b00};
  assign ofs_b    = {14'd0, idx_q - A_N, 2'b00};
  assign req_addr = state_q == LOAD_RD ? (idx_q < A_N ? src_a_q + ofs : src_b_q + ofs_b) :
                    state_q == RES_RD  ? ACC_READ + ofs :
                    state_q == LOAD_WR ? ACC_WRITE + ofs : dst_q + ofs;

  assign m_valid_d = issue ? 1'b1 : (m_ack || tmo) ? 1'b0 : m_valid_q;
  assign m_addr_d  = issue ? req_addr : m_addr_q;
  assign m_wdata_d = issue ? (is_wr ? data_q : 32'h0) : m_wdata_q;
  assign m_wstrb_d = issue ? (is_wr ? 4'hF : 4'h0) : m_wstrb_q;
  assign wd_d      = issue ? 16'd0 : (m_valid_q && !m_mem_ready) ? wd_q + 16'd1 : wd_q;
  assign data_d    = m_ack && !is_wr ? m_mem_rdata : data_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == ERR) state_d = IDLE;
    else if (tmo) state_d = ERR;
    else if (m_ack)
      case (state_q)
        LOAD_RD: state_d = LOAD_WR;
        LOAD_WR: begin
          state_d = idx_q == LD_LAST ? RES_RD : LOAD_RD;
          idx_d   = idx_q == LD_LAST ? 16'd0 : idx_q + 16'd1;
        end
        RES_RD:  state_d = RES_WR;
        RES_WR: begin
          state_d = last_res ? IDLE : RES_RD;
          idx_d   = idx_q + 16'd1;
        end
        default: state_d = state_q;
      endcase
    if (start) begin
      state_d = LOAD_RD;
      idx_d   = s_mem_wdata[1] ? A_N : 16'd0;
    end
  end

  // Flag sets are applied after clears so a same-edge clear loses to completion/error.
  always_comb begin
    done_d  = done_q;
    error_d = error_q;
    if (st_wr && s_mem_wdata[1]) done_d = 1'b0;
    if (st_wr && s_mem_wdata[2]) error_d = 1'b0;
    if (start) begin
      done_d  = 1'b0;
      error_d = 1'b0;
    end
    if (m_ack && last_res) done_d = 1'b1;
    if (tmo) error_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      wd_q      <= '0;
      data_q    <= '0;
      m_valid_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wstrb_q <= '0;
      src_a_q   <= '0;
      src_b_q   <= '0;
      dst_q     <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      s_ready_q <= 1'b0;
      s_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wd_q      <= wd_d;
      data_q    <= data_d;
      m_valid_q <= m_valid_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wstrb_q <= m_wstrb_d;
      src_a_q   <= src_a_d;
      src_b_q   <= src_b_d;
      dst_q     <= dst_d;
      done_q    <= done_d;
      error_q   <= error_d;
      s_ready_q <= s_ready_d;
      s_rdata_q <= s_rdata_d;
    end

  assign s_mem_ready = s_ready_q;
  assign s_mem_rdata = s_rdata_q;
  assign m_mem_valid = m_valid_q;
  assign m_mem_addr  = m_addr_q;
  assign m_mem_wdata = m_wdata_q;
  assign m_mem_wstrb = m_wstrb_q;
  assign irq         = done_q | error_q;
endmodule

// File: tb/tb_acc_sequencer.sv
// tb_acc_sequencer: scoreboard bench for acc_sequencer with a lingering-ready memory/accelerator model
module tb_acc_sequencer;
  localparam logic [31:0] CFG = 32'h0160_0000;
  localparam logic [31:0] ACC_WRITE = 32'h0110_0000;
  localparam logic [31:0] ACC_READ = 32'h0130_0000;
  localparam logic [31:0] A_VAL = 32'h0403_0201;
  localparam logic [31:0] B_VAL = 32'h0101_0101;

  logic        clk = 1'b0, reset = 1'b1;
  logic        s_mem_valid = 1'b0, s_mem_ready;
  logic [31:0] s_mem_addr = '0, s_mem_wdata = '0, s_mem_rdata;
  logic [3:0]  s_mem_wstrb = '0;
  logic        m_mem_valid, m_mem_ready = 1'b0, busy, irq;
  logic [31:0] m_mem_addr, m_mem_wdata, m_mem_rdata = '0;
  logic [3:0]  m_mem_wstrb;

  typedef struct {logic we; logic [31:0] addr; logic [31:0] data;} xfer_t;
  xfer_t       sb[$];
  logic [31:0] mem[logic [31:0]];
  logic [31:0] acc[0:4];
  int          checks = 0, errors = 0;
  int          vcnt = 0, lcnt = 0, linger = 1, stall_n = 0, req_num = 0, last_vlen = 0, acks = 0;
  logic        prev_valid = 1'b0, pr;
  xfer_t       e;

  acc_sequencer dut (
    .clk(clk), .reset(reset),
    .s_mem_valid(s_mem_valid), .s_mem_addr(s_mem_addr), .s_mem_wdata(s_mem_wdata), .s_mem_wstrb(s_mem_wstrb),
    .s_mem_ready(s_mem_ready), .s_mem_rdata(s_mem_rdata),
    .m_mem_valid(m_mem_valid), .m_mem_addr(m_mem_addr), .m_mem_wdata(m_mem_wdata), .m_mem_wstrb(m_mem_wstrb),
    .m_mem_ready(m_mem_ready), .m_mem_rdata(m_mem_rdata),
    .busy(busy), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Accelerator column s: sum over rows r of A[r] * B[r][s], 8-bit elements, 16-bit result.
  function automatic logic [15:0] col(input logic [31:0] a, input logic [31:0] b0, input logic [31:0] b1,
                                      input logic [31:0] b2, input logic [31:0] b3, input int s);
    logic [31:0] bw[4];
    logic [15:0] sum;
    bw[0] = b0; bw[1] = b1; bw[2] = b2; bw[3] = b3;
    sum = 16'd0;
    for (int r = 0; r < 4; r++) sum += 16'(a[8*r +: 8]) * 16'(bw[r][8*s +: 8]);
    return sum;
  endfunction

  function automatic logic [31:0] exp_res(input int k);
    return {col(A_VAL, B_VAL, B_VAL, B_VAL, B_VAL, 2*k+1), col(A_VAL, B_VAL, B_VAL, B_VAL, B_VAL, 2*k)};
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    int k;
    if (a >= ACC_READ && a < ACC_READ + 32'd8) begin
      k = int'((a - ACC_READ) >> 2);
      return {col(acc[0], acc[1], acc[2], acc[3], acc[4], 2*k+1), col(acc[0], acc[1], acc[2], acc[3], acc[4], 2*k)};
    end
    return mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
  endfunction

  // Bus slave: ready one cycle after valid, lingers `linger` cycles after valid falls,
  // never acks request number stall_n. Every ack is checked against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      vcnt = 0; lcnt = 0; m_mem_ready = 1'b0; prev_valid = 1'b0;
    end else begin
      pr = m_mem_ready;
      if (m_mem_valid) begin
        vcnt++;
        if (vcnt == 1) begin
          req_num++;
          checks++;
          if (prev_valid || pr) begin
            errors++;
            $display("FAIL turnaround: request %0d issued after cycle with valid=%0b ready=%0b, required 0/0", req_num, prev_valid, pr);
          end
        end
        last_vlen = vcnt;
        lcnt = linger;
        m_mem_ready = vcnt >= 2 && req_num != stall_n;
      end else begin
        vcnt = 0;
        if (m_mem_ready && lcnt > 0) lcnt--;
        else m_mem_ready = 1'b0;
      end
      m_mem_rdata = model_rd(m_mem_addr);
      if (m_mem_valid && m_mem_ready) begin
        acks++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL xfer: unexpected transfer addr=%h wstrb=%h wdata=%h, none expected", m_mem_addr, m_mem_wstrb, m_mem_wdata);
        end else begin
          e = sb.pop_front();
          if (m_mem_addr !== e.addr || m_mem_wstrb !== (e.we ? 4'hF : 4'h0) || (e.we && m_mem_wdata !== e.data)) begin
            errors++;
            $display("FAIL xfer: got addr=%h wstrb=%h wdata=%h, expected addr=%h wstrb=%h wdata=%h",
                     m_mem_addr, m_mem_wstrb, m_mem_wdata, e.addr, e.we ? 4'hF : 4'h0, e.data);
          end
        end
        if (m_mem_wstrb == 4'hF) begin
          if (m_mem_addr >= ACC_WRITE && m_mem_addr < ACC_WRITE + 32'd20) acc[int'((m_mem_addr - ACC_WRITE) >> 2)] = m_mem_wdata;
          else mem[m_mem_addr] = m_mem_wdata;
        end
      end
      prev_valid = m_mem_valid;
    end
  end

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    s_mem_valid = 1'b1; s_mem_addr = a; s_mem_wdata = d; s_mem_wstrb = s;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (s_mem_ready) break;
    end
    checks++;
    if (s_mem_ready !== 1'b1) begin
      errors++;
      $display("FAIL cpu_write_ack: addr=%h ready=%b, required 1", a, s_mem_ready);
    end
    s_mem_valid = 1'b0; s_mem_wstrb = 4'h0;
  endtask

  task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    s_mem_valid = 1'b1; s_mem_addr = a; s_mem_wstrb = 4'h0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (s_mem_ready) break;
    end
    checks++;
    if (s_mem_ready !== 1'b1) begin
      errors++;
      $display("FAIL cpu_read_ack: addr=%h ready=%b, required 1", a, s_mem_ready);
    end
    d = s_mem_rdata;
    s_mem_valid = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    for (cyc = 0; cyc < 1000 && busy; cyc++) @(negedge clk);
  endtask

  task automatic setup();
    mem.delete();
    mem[32'h100] = A_VAL;
    for (int j = 0; j < 4; j++) mem[32'h200 + 32'(4*j)] = B_VAL;
    cpu_write(CFG + 8, 32'h100, 4'hF);
    cpu_write(CFG + 12, 32'h200, 4'hF);
    cpu_write(CFG + 16, 32'h300, 4'hF);
  endtask

  task automatic push_seq(input bit skip);
    if (!skip) begin
      sb.push_back('{1'b0, 32'h100, 32'h0});
      sb.push_back('{1'b1, ACC_WRITE, A_VAL});
    end
    for (int j = 0; j < 4; j++) begin
      sb.push_back('{1'b0, 32'h200 + 32'(4*j), 32'h0});
      sb.push_back('{1'b1, ACC_WRITE + 32'(4*(1+j)), B_VAL});
    end
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{1'b0, ACC_READ + 32'(4*k), 32'h0});
      sb.push_back('{1'b1, 32'h300 + 32'(4*k), exp_res(k)});
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (3) @(negedge clk);
    checks++;
    if ({m_mem_valid, busy, irq, s_mem_ready} !== 4'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid/busy/irq/sready=%b, required 0000", {m_mem_valid, busy, irq, s_mem_ready});
    end
    reset = 1'b0;
    for (int r = 0; r < 5; r++) begin
      cpu_read(CFG + 32'(4*r), d);
      checks++;
      if (d !== 32'h0) begin
        errors++;
        $display("FAIL reset_reg%0d: read %h, required 0", r, d);
      end
    end
  endtask

  task automatic test_regs();
    logic [31:0] d;
    logic [31:0] bad[2];
    logic seen;
    cpu_write(CFG + 8, 32'hFFFF_FFFF, 4'hF);
    cpu_write(CFG + 8, 32'h1234_567B, 4'b0101);
    cpu_read(CFG + 8, d);
    checks++;
    if (d !== 32'hFF34_FF78) begin
      errors++;
      $display("FAIL byte_mask: SRC_A=%h, required ff34ff78", d);
    end
    bad[0] = CFG + 20; bad[1] = CFG + 2;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      s_mem_valid = 1'b1; s_mem_addr = bad[i]; s_mem_wdata = 32'h0; s_mem_wstrb = 4'hF;
      seen = 1'b0;
      repeat (4) begin
        @(negedge clk);
        seen |= s_mem_ready;
      end
      s_mem_valid = 1'b0; s_mem_wstrb = 4'h0;
      checks++;
      if (seen) begin
        errors++;
        $display("FAIL decode: addr %h acked=%b, required 0", bad[i], seen);
      end
    end
  endtask

  task automatic run_and_check(input string name, input bit skip, input int n, input int max_cyc);
    logic [31:0] d;
    int cyc, a0;
    a0 = acks;
    push_seq(skip);
    cpu_write(CFG, skip ? 32'h3 : 32'h1, 4'h1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy_rise: busy=%b, required 1", name, busy);
    end
    wait_idle(cyc);
    checks++;
    if (cyc > max_cyc) begin
      errors++;
      $display("FAIL %s_cycles: %0d cycles, required <= %0d", name, cyc, max_cyc);
    end
    checks++;
    if (acks - a0 != n || sb.size() != 0) begin
      errors++;
      $display("FAIL %s_count: %0d transfers with %0d left, required %0d with 0 left", name, acks - a0, sb.size(), n);
    end
    cpu_read(CFG + 4, d);
    checks++;
    if (d !== 32'h2 || irq !== 1'b1) begin
      errors++;
      $display("FAIL %s_status: STATUS=%h irq=%b, required 2 and 1", name, d, irq);
    end
    for (int k = 0; k < 2; k++) begin
      d = mem.exists(32'h300 + 32'(4*k)) ? mem[32'h300 + 32'(4*k)] : 32'hX;
      checks++;
      if (d !== exp_res(k)) begin
        errors++;
        $display("FAIL %s_result%0d: mem=%h, required %h", name, k, d, exp_res(k));
      end
    end
    cpu_write(CFG + 4, 32'h2, 4'h1);
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL %s_irq_clear: irq=%b, required 0", name, irq);
    end
  endtask

  task automatic test_full();
    setup();
    run_and_check("full", 1'b0, 14, 60);
  endtask

  task automatic test_skip_a();
    setup();
    run_and_check("skip", 1'b1, 12, 60);
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    int cyc, a0;
    setup();
    a0 = acks;
    stall_n = req_num + 3;
    sb.push_back('{1'b0, 32'h100, 32'h0});
    sb.push_back('{1'b1, ACC_WRITE, A_VAL});
    cpu_write(CFG, 32'h1, 4'h1);
    wait_idle(cyc);
    stall_n = 0;
    checks++;
    if (last_vlen != 255 || acks - a0 != 2 || sb.size() != 0) begin
      errors++;
      $display("FAIL timeout_len: valid held %0d cycles after %0d acks, required 255 after 2", last_vlen, acks - a0);
    end
    cpu_read(CFG + 4, d);
    checks++;
    if (d !== 32'h4 || irq !== 1'b1 || m_mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_status: STATUS=%h irq=%b valid=%b, required 4,1,0", d, irq, m_mem_valid);
    end
    cpu_write(CFG + 4, 32'h4, 4'h1);
    cpu_read(CFG + 4, d);
    checks++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: STATUS=%h irq=%b, required 0 and 0", d, irq);
    end
  endtask

  task automatic test_busy_writes();
    logic [31:0] d;
    int cyc, a0;
    setup();
    a0 = acks;
    push_seq(1'b0);
    cpu_write(CFG, 32'h1, 4'h1);
    cpu_write(CFG, 32'h3, 4'h1);
    cpu_write(CFG + 8, 32'h999, 4'hF);
    wait_idle(cyc);
    checks++;
    if (acks - a0 != 14 || sb.size() != 0) begin
      errors++;
      $display("FAIL busy_count: %0d transfers with %0d left, required 14 with 0 left", acks - a0, sb.size());
    end
    cpu_read(CFG + 8, d);
    checks++;
    if (d !== 32'h100) begin
      errors++;
      $display("FAIL busy_srca: SRC_A=%h, required 00000100", d);
    end
    repeat (4) @(negedge clk);
    cpu_read(CFG + 4, d);
    checks++;
    if (d !== 32'h2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_restart: STATUS=%h busy=%b, required 2 and 0", d, busy);
    end
    cpu_write(CFG + 4, 32'h2, 4'h1);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int r0;
    setup();
    push_seq(1'b0);
    r0 = req_num;
    cpu_write(CFG, 32'h1, 4'h1);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (req_num >= r0 + 5) break;
    end
    checks++;
    if (req_num < r0 + 5) begin
      errors++;
      $display("FAIL rst_reach: %0d requests seen, required 5", req_num - r0);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({m_mem_valid, busy, irq} !== 3'b0) begin
      errors++;
      $display("FAIL rst_async: valid/busy/irq=%b, required 000", {m_mem_valid, busy, irq});
    end
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    r0 = req_num;
    repeat (6) @(negedge clk);
    checks++;
    if (req_num != r0 || m_mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_quiet: %0d requests after reset, required 0", req_num - r0);
    end
    for (int r = 1; r < 5; r++) begin
      cpu_read(CFG + 32'(4*r), d);
      checks++;
      if (d !== 32'h0) begin
        errors++;
        $display("FAIL rst_reg%0d: read %h, required 0", r, d);
      end
    end
    setup();
    run_and_check("rst_rerun", 1'b0, 14, 60);
  endtask

  task automatic test_linger();
    linger = 2;
    setup();
    run_and_check("linger", 1'b0, 14, 80);
    linger = 1;
  endtask

  initial begin
    test_reset();
    test_regs();
    test_full();
    test_skip_a();
    test_timeout();
    test_busy_writes();
    test_reset_mid();
    test_linger();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
